mult_seq_ctrl: RTL and testbench



---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_seq_ctrl_if.sv | 38 +++
 rtl/mult_iter_cnt.sv | 35 +++
 rtl/mult_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared constants and the FSM state type for the sequential shift-and-add
// multiplier controller (mult_seq_ctrl) and its iteration counter.
//   WIDTH     : operand width, a multiple of 4 so it maps onto 4-bit CLA groups
//   CNT_W     : iteration counter width, clog2(WIDTH)+1
//   LAST_ITER : counter value at which the final RUN iteration happens
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int WIDTH     = 16;
  localparam int CNT_W     = 5;
  localparam int LAST_ITER = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl_if
// Bundles the pipeline handshake and the external adder connection of the
// multiplier controller.
//   start, op_a, op_b     : request and operands from the pipeline
//   busy, done, product   : status and 2*WIDTH-bit result to the pipeline
//   add_a, add_b, add_cin : operands driven into the shared CLA adder
//   add_sum, add_cout     : combinational result returned by the adder
// Modports:
//   master : pipeline + adder side (drives requests and adder results)
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface mult_seq_ctrl_if;
  import mult_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  modport master (
    output start, op_a, op_b, add_sum, add_cout,
    input  busy, done, product, add_a, add_b, add_cin
  );

  modport slave (
    input  start, op_a, op_b, add_sum, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );

endinterface

// File: rtl/mult_iter_cnt.sv
// -----------------------------------------------------------------------------
// mult_iter_cnt
// Loadable up-counter that tracks RUN iterations and flags the last one.
// Ports:
//   clk     : system clock
//   rst_n   : synchronous active-low reset, clears the count
//   i_load  : restart the count at zero (a new operation was accepted)
//   i_en    : advance by one (one multiplier iteration completed)
//   o_tc    : terminal count, high while the count equals LAST_ITER
// -----------------------------------------------------------------------------
module mult_iter_cnt
  import mult_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CNT_W'(LAST_ITER));

endmodule

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
// Sequential unsigned shift-and-add multiplier controller. One WIDTH-bit
// carry-lookahead adder outside this block is time-shared over WIDTH
// iterations; this block owns operand latching, the iteration counter and
// the IDLE/RUN/DONE FSM.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset; aborts a running operation
//   bus   : mult_seq_ctrl_if.slave (start/op_a/op_b/busy/done/product and
//           the add_a/add_b/add_cin/add_sum/add_cout adder connection)
// Configuration:
//   MULT_ZERO_SKIP_EN : when defined, a zero operand at acceptance jumps
//                       straight to DONE with product 0 and no RUN phase.
// -----------------------------------------------------------------------------
module mult_seq_ctrl
  import mult_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  mult_seq_ctrl_if.slave  bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_finish;
  logic               w_zero;
  logic               w_tc;
  logic               w_run;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [2*WIDTH-1:0] w_acc_shift;

`ifdef MULT_ZERO_SKIP_EN
  assign w_zero = (bus.op_a == '0) || (bus.op_b == '0);
`else
  assign w_zero = 1'b0;
`endif

  assign w_run = (r_state == RUN);

  // Adder carry-out becomes the accumulator MSB, so full-scale products
  // never lose their top bit.
  assign w_acc_shift = {bus.add_cout, bus.add_sum, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      // DONE accepts a new start exactly like IDLE for back-to-back operation.
      IDLE, DONE: begin
        w_state_next = IDLE;
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = w_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_tc) begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      if (w_accept) begin
        r_mcand <= bus.op_a;
        r_acc   <= {{WIDTH{1'b0}}, bus.op_b};
        if (w_zero) begin
          r_product <= '0;
        end
      end else if (w_run) begin
        r_acc <= w_acc_shift;
      end
      // The last iteration's shifted value is the finished product.
      if (w_finish) begin
        r_product <= w_acc_shift;
      end
    end
  end

  mult_iter_cnt u_iter_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_en   (w_run),
    .o_tc   (w_tc)
  );

  // Adder inputs are forced to zero outside RUN so the ALU can share it.
  assign bus.add_a   = w_run ? r_acc[2*WIDTH-1:WIDTH] : '0;
  assign bus.add_b   = (w_run && r_acc[0]) ? r_mcand : '0;
  assign bus.add_cin = 1'b0;
  assign bus.busy    = w_run;
  assign bus.done    = (r_state == DONE);
  assign bus.product = r_product;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl_if bus ();

  // Behavioural stand-in for the shared carry-lookahead adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'h0, bus.add_cin};

  mult_seq_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation, follow it to done, check latency, busy length,
  // per-iteration add_b, product hold while running, and the final product.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_prod, input int exp_lat, input int exp_busy);
    logic [31:0] prev;
    int k;
    int nb;
    prev = bus.product;
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
    tick();
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    k = 0; nb = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) begin
        nb++;
        if (k < 16) chk({tag, "_add_b"}, 64'(bus.add_b), 64'(b[k] ? a : 16'h0));
      end
      chk({tag, "_hold"}, 64'(bus.product), 64'(prev));
      tick();
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    chk({tag, "_product"}, 64'(bus.product), 64'(exp_prod));
    chk({tag, "_done"}, 64'(bus.done), 64'(1));
    tick();
    chk({tag, "_done_single"}, 64'(bus.done), 64'(0));
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'(0));
    $display("op %s: 0x%0h * 0x%0h -> 0x%0h after %0d cycles", tag, a, b, bus.product, k);
  endtask

  initial begin
    int ndone;
    int k_done;
    logic [31:0] p_done;

    // Reset
    rst_n = 1'b0; bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    tick(); tick();
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_product", 64'(bus.product), 64'(0));
    chk("rst_add_a", 64'(bus.add_a), 64'(0));
    chk("rst_add_b", 64'(bus.add_b), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(bus.busy), 64'(0));
    $display("reset: busy=%0d done=%0d product=0x%0h", bus.busy, bus.done, bus.product);

    // Basic and full-scale products
    run_op("mul3x5", 16'h0003, 16'h0005, 32'h0000000F, 16, 16);
    run_op("mulFFFFxFFFF", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 16);

    // start raised during RUN must be ignored
    bus.start = 1'b1; bus.op_a = 16'd7; bus.op_b = 16'd6;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.start = 1'b1; bus.op_a = 16'd9; bus.op_b = 16'd9;
    tick();
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    ndone = 0; k_done = -1; p_done = '0;
    for (int i = 6; i <= 26; i++) begin
      if (bus.done) begin
        ndone++; k_done = i; p_done = bus.product;
      end
      tick();
    end
    chk("runstart_done_count", 64'(ndone), 64'(1));
    chk("runstart_latency", 64'(k_done), 64'(16));
    chk("runstart_product", 64'(p_done), 64'(42));
    $display("op start_in_run: 7*6 -> 0x%0h, done pulses=%0d", p_done, ndone);

    // Reset in the middle of an operation
    bus.start = 1'b1; bus.op_a = 16'h0055; bus.op_b = 16'h0003;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_done", 64'(bus.done), 64'(0));
    chk("midrst_product", 64'(bus.product), 64'(0));
    chk("midrst_add_a", 64'(bus.add_a), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("midrst_no_done", 64'(bus.done), 64'(0));
    $display("op mid_reset: busy=%0d done=%0d product=0x%0h", bus.busy, bus.done, bus.product);
    run_op("mul2x2", 16'h0002, 16'h0002, 32'h00000004, 16, 16);

    // Back-to-back: start held in DONE
    bus.start = 1'b1; bus.op_a = 16'h00FF; bus.op_b = 16'h0003;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("b2b_first_done", 64'(bus.done), 64'(1));
    chk("b2b_first_product", 64'(bus.product), 64'(32'h000002FD));
    bus.start = 1'b1; bus.op_a = 16'h1234; bus.op_b = 16'h0010;
    tick();
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    chk("b2b_busy_now", 64'(bus.busy), 64'(1));
    chk("b2b_done_low", 64'(bus.done), 64'(0));
    for (int i = 0; i < 16; i++) begin
      chk("b2b_hold", 64'(bus.product), 64'(32'h000002FD));
      tick();
    end
    chk("b2b_second_done", 64'(bus.done), 64'(1));
    chk("b2b_second_product", 64'(bus.product), 64'(32'h00012340));
    $display("op back_to_back: 0x1234*0x0010 -> 0x%0h", bus.product);
    tick();

    // Zero operand
`ifdef MULT_ZERO_SKIP_EN
    run_op("zero", 16'h0000, 16'hABCD, 32'h00000000, 0, 0);
`else
    run_op("zero", 16'h0000, 16'hABCD, 32'h00000000, 16, 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
